// File: rtl/alu_mdu_pkg.sv
// Shared types for alu_mdu: op encodings, FSM state enum and the invalid-op result pattern.
// Operand width defaults to `DATA_WIDTH (32) when not set by the build.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package alu_mdu_pkg;

    // Base ALU codes occupy op[3:0] with op[4]=0; 0xA-0xF are NOP (result 0).
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;
    localparam logic [3:0] ALU_NOP  = 4'hF;

    localparam logic [4:0] ALU_MUL    = 5'h10;
    localparam logic [4:0] ALU_MULH   = 5'h11;
    localparam logic [4:0] ALU_MULHSU = 5'h12;
    localparam logic [4:0] ALU_MULHU  = 5'h13;
    localparam logic [4:0] ALU_DIV    = 5'h14;
    localparam logic [4:0] ALU_DIVU   = 5'h15;
    localparam logic [4:0] ALU_REM    = 5'h16;
    localparam logic [4:0] ALU_REMU   = 5'h17;

    localparam logic [31:0] INVALID_PAT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op >= ALU_DIV) && (op <= ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_mdu_base.sv
// alu_mdu_base: combinational datapath for the single-cycle base ALU ops.
// Shift amounts use the low SHAMT_W bits of b; unassigned codes yield 0.
module alu_mdu_base
    import alu_mdu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage execute unit; registered base ALU ops plus iterative RV32M mul/div/rem.
// Optional ALU_MDU_FAST_MUL_EN swaps the shift-add multiplier for a single wide product.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN    = `DATA_WIDTH,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] INV_RES = XLEN'(INVALID_PAT);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        mop_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd_q, hi_q, lo_q;

    logic              accept, is_mul, is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic              div_zero, div_ovf, special, res_neg_in, load_out;
    logic [XLEN-1:0]   a_abs, b_abs, base_y, special_res, imm_res, fix_res, load_val;
    logic [XLEN:0]     msum, dshift;
    logic              dfits;
    logic [2*XLEN-1:0] full, full_s;

    // Valid/ready: a beat moves on a rising edge where valid and ready are both high;
    // the sender holds valid and its data stable until that edge.
    assign in_ready = rst_n && (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign busy     = (state != ST_IDLE);

    assign is_mul = is_mul_op(op);
    assign is_div = is_div_op(op);

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        if (is_div) begin
            a_sgn = !op[0];
            b_sgn = !op[0];
        end else if (is_mul) begin
            a_sgn = (op[1:0] != 2'b11);
            b_sgn = !op[1];
        end
    end

    assign a_neg      = a_sgn && a[XLEN-1];
    assign b_neg      = b_sgn && b[XLEN-1];
    assign a_abs      = a_neg ? -a : a;
    assign b_abs      = b_neg ? -b : b;
    // Remainder follows the dividend; quotient and products follow the xor of signs.
    assign res_neg_in = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = (b == '0);
    assign div_ovf  = !op[0] && (a == MIN_VAL) && (b == '1);
    assign special  = is_div && (div_zero || div_ovf);

    always_comb begin
        if (div_zero) special_res = op[1] ? a : '1;
        else          special_res = op[1] ? '0 : a;
    end

    alu_mdu_base #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_base (
        .op (op[3:0]),
        .a  (a),
        .b  (b),
        .y  (base_y)
    );

    assign imm_res = special ? special_res : (op[4] ? INV_RES : base_y);

`ifdef ALU_MDU_FAST_MUL_EN
    logic signed [2*XLEN+1:0] prod_w;
    assign prod_w = $signed({a_neg, a}) * $signed({b_neg, b});
`endif

    assign msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign dshift = {hi_q, lo_q[XLEN-1]};
    assign dfits  = (dshift >= {1'b0, opnd_q});

    assign full   = {hi_q, lo_q};
    assign full_s = neg_q ? -full : full;

    always_comb begin
        if (mop_q[2]) begin
            if (mop_q[1]) fix_res = neg_q ? -hi_q : hi_q;
            else          fix_res = neg_q ? -lo_q : lo_q;
        end else begin
            fix_res = (mop_q[1:0] == 2'b00) ? full_s[XLEN-1:0] : full_s[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        load_val   = fix_res;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
`ifdef ALU_MDU_FAST_MUL_EN
                        state_next = ST_FIX;
`else
                        state_next = ST_MUL;
`endif
                    end else if (is_div && !special) begin
                        state_next = ST_DIV;
                    end else begin
                        load_out = 1'b1;
                        load_val = imm_res;
                    end
                end
            end
            ST_MUL, ST_DIV: if (cnt == '0) state_next = ST_FIX;
            ST_FIX: begin
                state_next = ST_IDLE;
                load_out   = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
            load_out   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mop_q     <= '0;
            neg_q     <= 1'b0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load_out) begin
                out_valid <= 1'b1;
                result    <= load_val;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mop_q <= op[2:0];
                        neg_q <= res_neg_in;
                        cnt   <= CNT_W'(XLEN-1);
                        hi_q  <= '0;
                        if (is_mul) begin
`ifdef ALU_MDU_FAST_MUL_EN
                            {hi_q, lo_q} <= prod_w[2*XLEN-1:0];
                            neg_q        <= 1'b0;
`else
                            opnd_q <= a_abs;
                            lo_q   <= b_abs;
`endif
                        end else begin
                            opnd_q <= b_abs;
                            lo_q   <= a_abs;
                        end
                    end
                end
                ST_MUL: begin
                    hi_q <= msum[XLEN:1];
                    lo_q <= {msum[0], lo_q[XLEN-1:1]};
                    cnt  <= cnt - CNT_W'(1);
                end
                ST_DIV: begin
                    hi_q <= dfits ? (dshift[XLEN-1:0] - opnd_q) : dshift[XLEN-1:0];
                    lo_q <= {lo_q[XLEN-2:0], dfits};
                    cnt  <= cnt - CNT_W'(1);
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized and directed checks of alu_mdu against an arithmetic reference model.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam int XLEN = 32;

    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [XLEN-1:0] exp_q[$];

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: plain 64-bit / integer arithmetic from the op definitions.
    function automatic logic [31:0] ref_model(input logic [4:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        logic [63:0] sx, sy, ux, uy, p;
        int sa, sb;
        logic [31:0] r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        sa = x;
        sb = y;
        r  = 32'hDEADBEEF;
        case (o)
            {1'b0, ALU_ADD}:  r = x + y;
            {1'b0, ALU_SUB}:  r = x - y;
            {1'b0, ALU_SLL}:  r = x << y[4:0];
            {1'b0, ALU_SLT}:  r = (sa < sb) ? 32'd1 : 32'd0;
            {1'b0, ALU_SLTU}: r = (x < y) ? 32'd1 : 32'd0;
            {1'b0, ALU_XOR}:  r = x ^ y;
            {1'b0, ALU_SRL}:  r = x >> y[4:0];
            {1'b0, ALU_SRA}:  r = $signed(x) >>> y[4:0];
            {1'b0, ALU_OR}:   r = x | y;
            {1'b0, ALU_AND}:  r = x & y;
            5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F: r = 32'd0;
            OP_MUL:    begin p = sx * sy; r = p[31:0];  end
            OP_MULH:   begin p = sx * sy; r = p[63:32]; end
            OP_MULHSU: begin p = sx * uy; r = p[63:32]; end
            OP_MULHU:  begin p = ux * uy; r = p[63:32]; end
            OP_DIV: begin
                if (y == 0) r = 32'hFFFFFFFF;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h80000000;
                else r = 32'(sa / sb);
            end
            OP_DIVU: r = (y == 0) ? 32'hFFFFFFFF : x / y;
            OP_REM: begin
                if (y == 0) r = x;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'd0;
                else r = 32'(sa % sb);
            end
            OP_REMU: r = (y == 0) ? x : x % y;
            default: r = 32'hDEADBEEF;
        endcase
        return r;
    endfunction

    function automatic bit is_long(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        bit ovf;
        ovf = (o == OP_DIV || o == OP_REM) && x == 32'h80000000 && y == 32'hFFFFFFFF;
        if (o >= OP_MUL && o <= OP_MULHU) return 1'b1;
        if (o >= OP_DIV && o <= OP_REMU)  return (y != 0) && !ovf;
        return 1'b0;
    endfunction

    // driver: issue one op, wait for its result, check value/latency, optionally stall the consumer
    task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int stall);
        logic [31:0] e;
        int lat, waited, exp_lat;
        bit lng;
        string tag;
        tag = $sformatf("op%02h_%08h_%08h", o, x, y);
        e = ref_model(o, x, y);
        exp_q.push_back(e);
        lng = is_long(o, x, y);
        exp_lat = lng ? XLEN + 2 : 1;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        op = 5'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (lat == 2) begin
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_in_ready_busy"}, in_ready, 0);
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, result, exp_q.pop_front());
        if (stall > 0) begin
            out_ready = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk({tag, "_hold_result"}, result, e);
                chk({tag, "_hold_valid"}, out_valid, 1);
                chk({tag, "_hold_in_ready"}, in_ready, 0);
            end
            out_ready = 1'b1;
        end
    endtask

    logic [4:0]  d_op[10] = '{{1'b0, ALU_ADD}, {1'b0, ALU_SRA}, OP_MULH, OP_MULHU, OP_DIV,
                              OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] d_a[10]  = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h80000000, 32'h80000000, 32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] d_b[10]  = '{32'd1, 32'h24, 32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd0, 32'd0, 32'd2, 32'd2};

    initial begin
        int seen;
        logic [4:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) do_op(d_op[i], d_a[i], d_b[i], 0);

        // backpressure: result held, next op refused until the consume edge
        @(negedge clk);
        out_ready = 1'b0;
        op = {1'b0, ALU_ADD}; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        @(negedge clk);
        op = {1'b0, ALU_ADD}; a = 32'd5; b = 32'd6;
        repeat (5) begin
            @(negedge clk);
            chk("bp_result", result, 32'd3);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_b2b_valid", out_valid, 1);
        chk("bp_b2b_result", result, 32'd11);
        @(negedge clk);

        // flush beats a simultaneous request
        op = {1'b0, ALU_ADD}; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_wins", out_valid, 0);

        // flush mid-DIVU, then ADD 3+4
        op = OP_DIVU; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("divu_busy", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        op = {1'b0, ALU_ADD}; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("flush_add_valid", out_valid, 1);
        chk("flush_add_result", result, 32'd7);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_stale", seen, 0);

        // reset pulsed mid-MUL
        op = OP_MUL; a = 32'd123; b = 32'd456; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mul_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_result", seen, 0);

        // randomized ops with corner operands and random consumer stalls
        for (int i = 0; i < 60; i++) begin
            ro = 5'($urandom_range(0, 31));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 5));
                3: ra = -32'($urandom_range(1, 100));
                default: ;
            endcase
            do_op(ro, ra, rb, $urandom_range(0, 2));
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, sequential execute unit for the TinyV core.
- Implements the base integer ALU ops with a registered result, plus the RV32M multiply/divide/remainder ops as iterative multi-cycle operations.
- Valid/ready on input and output so the pipeline can stall on long ops.
- Sits in the EX stage and replaces the purely combinational ALU.

Parameters:
- XLEN, `DATA_WIDTH (32): operand/result width; must be a power of two, at least 8.
- SHAMT_W, $clog2(XLEN): shift-amount bits taken from b.
- INVALID_PAT, 32'hDEADBEEF: result for invalid op, zero-extended or truncated to XLEN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight op.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  unit can accept this cycle.
- op  in  5  0x00-0x0F: existing 4-bit ALU codes; 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU, 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU; 0x18-0x1F invalid.
- a, b  in  XLEN  operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  registered result.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; out_valid=0, result=0, busy=0, in_ready=0 while reset is asserted.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A transfer occurs when in_valid && in_ready.
- Output register holds result/out_valid stable until out_valid && out_ready. A back-to-back accept and consume in the same cycle is legal.
- Base ops, accepted in cycle N: out_valid in cycle N+1.
  - Shifts use b[SHAMT_W-1:0].
  - SLT/SLTU return 1 or 0.
  - ADD/SUB wrap modulo 2^XLEN.
  - NOP returns 0.
  - Invalid op returns INVALID_PAT.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE: on accept of a mul op -> MUL; div/rem op -> DIV (except the special cases below); base op -> stays in IDLE and loads the output register.
  - MUL: radix-2 shift-add over absolute values, XLEN iterations (counter XLEN-1 down to 0), then -> FIX.
  - DIV: restoring division over absolute values, XLEN iterations, then -> FIX.
  - FIX: apply sign, select low or high half (MUL vs MULH*) or quotient/remainder, load output, -> IDLE.
  - Latency: accept at N -> out_valid at N+XLEN+2 for all mul/div ops.
- Sign rules:
  - MULH: signed×signed.
  - MULHSU: signed a × unsigned b.
  - DIV/REM: quotient truncates toward zero; remainder takes the sign of the dividend.
- Special cases (no iteration; out_valid at N+1):
  - b==0: DIV/DIVU return all ones; REM/REMU return a.
  - Signed overflow (a=MIN, b=-1): DIV returns MIN; REM returns 0.
- busy=1 in MUL, DIV and FIX.
- Operands and op are latched at accept; later input changes are ignored.
- flush:
  - Wins over in_valid in the same cycle.
  - Next cycle: state=IDLE, out_valid=0, counter cleared.
  - An un-consumed result is discarded.
- Reset asserted mid-op: immediate return to reset values; no partial result is ever presented.

Optional Feature:
- Macro ALU_MDU_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single 2XLEN-bit signed product, computed in IDLE and registered via FIX. Mul latency becomes N+2. Div/rem are unchanged.
- Undefined: iterative multiplier as described above. No `*` operator is inferred.

Decomposition:
- Shared include types.sv gains:
  - the 5-bit op encodings (`ALU_MUL .. `ALU_REMU);
  - the alu_mdu state enum;
  - INVALID_PAT.
  - The existing 4-bit `ALU_* codes remain valid as op[3:0] with op[4]=0.
- One sub-module, alu_mdu_base: combinational base-op datapath parametrised by XLEN. The top level holds the FSM, the iterative datapath and the output register.

Test Plan:
- ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid at N+1, result=0; SRA a=0x80000000, b=0x24 -> 0xF8000000 (shift 4).
- MULH a=0xFFFFFFFF (-1), b=0x00000002 -> result 0xFFFFFFFF at N+34; MULHU with the same operands -> 0x00000001.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at N+1; REM with the same operands -> 0; DIVU a=7, b=0 -> 0xFFFFFFFF; REMU a=7, b=0 -> 7.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF, at N+34. During the op in_ready=0 and busy=1.
- out_ready held 0 for 5 cycles after a result -> result stable and in_ready=0; a new in_valid is not accepted until the consume cycle.
- flush at iteration 10 of DIVU, then ADD 3+4 the next cycle -> no DIVU result ever appears; result=7. Repeat with rst_n pulsed low mid-MUL -> outputs go to zero immediately.
